// File: rtl/cpu_regfile_bypass_if.sv
// Register file bus: two write ports, packed read ports, scoreboard marks
// and the registered read/busy/fp/sp views returned by the file.
interface cpu_regfile_bypass_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 2
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic                       write_enable0_i;
    logic [ADDR_W-1:0]          reg_write_index0_i;
    logic [DATA_W-1:0]          value0_i;
    logic                       write_enable1_i;
    logic [ADDR_W-1:0]          reg_write_index1_i;
    logic [DATA_W-1:0]          value1_i;
    logic [NUM_RD*ADDR_W-1:0]   rd_index_i;
    logic [NUM_RD*DATA_W-1:0]   rd_value_o;
    logic                       mark_i;
    logic [ADDR_W-1:0]          mark_index_i;
    logic [DEPTH-1:0]           busy_o;
    logic [NUM_RD-1:0]          rd_busy_o;
    logic [DATA_W-1:0]          fp_o;
    logic [DATA_W-1:0]          sp_o;

    modport master (
        output write_enable0_i, reg_write_index0_i, value0_i,
        output write_enable1_i, reg_write_index1_i, value1_i,
        output rd_index_i, mark_i, mark_index_i,
        input  rd_value_o, busy_o, rd_busy_o, fp_o, sp_o
    );

    modport slave (
        input  write_enable0_i, reg_write_index0_i, value0_i,
        input  write_enable1_i, reg_write_index1_i, value1_i,
        input  rd_index_i, mark_i, mark_index_i,
        output rd_value_o, busy_o, rd_busy_o, fp_o, sp_o
    );
endinterface

// File: rtl/cpu_regfile_bypass.sv
// Two-write, N-read register file with write-first bypass, registered reads
// and a pending-write scoreboard.
module cpu_regfile_bypass #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 2,
    parameter int FP_IDX = 0,
    parameter int SP_IDX = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    cpu_regfile_bypass_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] FP_A = ADDR_W'(FP_IDX);
    localparam logic [ADDR_W-1:0] SP_A = ADDR_W'(SP_IDX);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_nxt;
    logic [DATA_W-1:0] rd_q [NUM_RD];
    logic [DATA_W-1:0] rd_nxt [NUM_RD];
    logic [NUM_RD-1:0] rbusy_q;
    logic [NUM_RD-1:0] rbusy_nxt;
    logic [ADDR_W-1:0] rd_idx [NUM_RD];

    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] w0;
    logic [ADDR_W-1:0] w1;

    assign we0 = bus.write_enable0_i;
    assign we1 = bus.write_enable1_i;
    assign w0  = bus.reg_write_index0_i;
    assign w1  = bus.reg_write_index1_i;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_port
        assign rd_idx[k] = bus.rd_index_i[k*ADDR_W +: ADDR_W];
        assign bus.rd_value_o[k*DATA_W +: DATA_W] = rd_q[k];
        assign bus.rd_busy_o[k] = rbusy_q[k];
    end

    // A new mark wins over a same-edge clear.
    always_comb begin
        busy_nxt = busy_q;
        if (we0) busy_nxt[w0] = 1'b0;
        if (we1) busy_nxt[w1] = 1'b0;
        if (bus.mark_i) busy_nxt[bus.mark_index_i] = 1'b1;
    end

    // Write port 1 has the final say, matching the array collision rule.
    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            rd_nxt[k] = regs[rd_idx[k]];
            if (we0 && rd_idx[k] == w0) rd_nxt[k] = bus.value0_i;
            if (we1 && rd_idx[k] == w1) rd_nxt[k] = bus.value1_i;
            rbusy_nxt[k] = busy_nxt[rd_idx[k]];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            for (int k = 0; k < NUM_RD; k++) rd_q[k] <= '0;
            busy_q  <= '0;
            rbusy_q <= '0;
        end else begin
            if (we0) regs[w0] <= bus.value0_i;
            if (we1) regs[w1] <= bus.value1_i;
            for (int k = 0; k < NUM_RD; k++) rd_q[k] <= rd_nxt[k];
            busy_q  <= busy_nxt;
            rbusy_q <= rbusy_nxt;
        end
    end

    assign bus.busy_o = busy_q;
    assign bus.fp_o   = regs[FP_A];
    assign bus.sp_o   = regs[SP_A];
endmodule

// File: tb/tb_cpu_regfile_bypass.sv
// Directed and random stimulus for cpu_regfile_bypass with a queue of
// expected registered outputs built from a reference register-file model.
module tb_cpu_regfile_bypass;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NR = 2;
    localparam int D  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpu_regfile_bypass_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

    cpu_regfile_bypass #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .FP_IDX(0), .SP_IDX(1)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [NR*DW-1:0] rd;
        logic [NR-1:0]    rb;
        logic [D-1:0]     busy;
        logic [DW-1:0]    fp;
        logic [DW-1:0]    sp;
    } exp_t;

    exp_t          sbq [$];
    logic [DW-1:0] mdl [D];
    logic [D-1:0]  mbusy;
    int            checks = 0;
    int            fails  = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.write_enable0_i    = 1'b0;
        bus.reg_write_index0_i = '0;
        bus.value0_i           = '0;
        bus.write_enable1_i    = 1'b0;
        bus.reg_write_index1_i = '0;
        bus.value1_i           = '0;
        bus.rd_index_i         = '0;
        bus.mark_i             = 1'b0;
        bus.mark_index_i       = '0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".rd"}, 64'(bus.rd_value_o), 64'd0);
        chk({tag, ".rb"}, 64'(bus.rd_busy_o), 64'd0);
        chk({tag, ".busy"}, 64'(bus.busy_o), 64'd0);
        chk({tag, ".fp"}, 64'(bus.fp_o), 64'd0);
        chk({tag, ".sp"}, 64'(bus.sp_o), 64'd0);
    endtask

    task automatic step(
        input string tag,
        input logic we0, input logic [AW-1:0] w0, input logic [DW-1:0] v0,
        input logic we1, input logic [AW-1:0] w1, input logic [DW-1:0] v1,
        input logic mk, input logic [AW-1:0] mi,
        input logic [AW-1:0] r0, input logic [AW-1:0] r1
    );
        logic [DW-1:0] nxt [D];
        logic [D-1:0]  nb;
        exp_t          e;
        bus.write_enable0_i    = we0;
        bus.reg_write_index0_i = w0;
        bus.value0_i           = v0;
        bus.write_enable1_i    = we1;
        bus.reg_write_index1_i = w1;
        bus.value1_i           = v1;
        bus.mark_i             = mk;
        bus.mark_index_i       = mi;
        bus.rd_index_i         = {r1, r0};
        // write-first view: the file as it stands after this edge
        nxt = mdl;
        if (we0) nxt[w0] = v0;
        if (we1) nxt[w1] = v1;
        nb = mbusy;
        if (we0) nb[w0] = 1'b0;
        if (we1) nb[w1] = 1'b0;
        if (mk) nb[mi] = 1'b1;
        e.rd   = {nxt[r1], nxt[r0]};
        e.rb   = {nb[r1], nb[r0]};
        e.busy = nb;
        e.fp   = nxt[0];
        e.sp   = nxt[1];
        sbq.push_back(e);
        @(posedge clk);
        #1;
        mdl   = nxt;
        mbusy = nb;
        e = sbq.pop_front();
        chk({tag, ".rd0"}, 64'(bus.rd_value_o[DW-1:0]), 64'(e.rd[DW-1:0]));
        chk({tag, ".rd1"}, 64'(bus.rd_value_o[2*DW-1:DW]),
            64'(e.rd[2*DW-1:DW]));
        chk({tag, ".rb"}, 64'(bus.rd_busy_o), 64'(e.rb));
        chk({tag, ".busy"}, 64'(bus.busy_o), 64'(e.busy));
        chk({tag, ".fp"}, 64'(bus.fp_o), 64'(e.fp));
        chk({tag, ".sp"}, 64'(bus.sp_o), 64'(e.sp));
    endtask

    initial begin
        for (int i = 0; i < D; i++) mdl[i] = '0;
        mbusy = '0;
        idle();
        #1;
        chk_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        step("wr2", 1, 4'd2, 32'h11223344, 0, 0, 0, 0, 0, 0, 0);
        step("rd2", 0, 0, 0, 0, 0, 0, 0, 0, 4'd2, 0);
        chk("rd2.lit", 64'(bus.rd_value_o[DW-1:0]), 64'h11223344);
        step("byp5", 1, 4'd5, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 0, 4'd5);
        chk("byp5.lit", 64'(bus.rd_value_o[2*DW-1:DW]), 64'hA5A5A5A5);
        step("arr5", 0, 0, 0, 0, 0, 0, 0, 0, 4'd5, 4'd5);
        step("col3", 1, 4'd3, 32'h1, 1, 4'd3, 32'h2, 0, 0, 4'd3, 0);
        chk("col3.lit", 64'(bus.rd_value_o[DW-1:0]), 64'h2);
        step("arr3", 0, 0, 0, 0, 0, 0, 0, 0, 4'd3, 4'd3);
        step("mk7", 0, 0, 0, 0, 0, 0, 1, 4'd7, 0, 4'd7);
        chk("mk7.lit", 64'(bus.busy_o[7]), 64'd1);
        step("mkwr7", 1, 4'd7, 32'h77, 0, 0, 0, 1, 4'd7, 4'd7, 4'd7);
        chk("mkwr7.lit", 64'(bus.busy_o[7]), 64'd1);
        step("mkagain7", 0, 0, 0, 0, 0, 0, 1, 4'd7, 0, 4'd7);
        step("wr7", 0, 0, 0, 1, 4'd7, 32'h78, 0, 0, 4'd7, 4'd7);
        chk("wr7.lit", 64'(bus.busy_o[7]), 64'd0);
        step("fpsp", 1, 4'd0, 32'h1000, 1, 4'd1, 32'h2000, 0, 0, 0, 4'd1);
        chk("fpsp.fp", 64'(bus.fp_o), 64'h1000);
        chk("fpsp.sp", 64'(bus.sp_o), 64'h2000);

        for (int n = 0; n < 24; n++) begin
            step($sformatf("rnd%0d", n),
                 1'($urandom), 4'($urandom), $urandom,
                 1'($urandom), 4'($urandom), $urandom,
                 1'($urandom), 4'($urandom),
                 4'($urandom), 4'($urandom));
        end

        step("mk9", 0, 0, 0, 0, 0, 0, 1, 4'd9, 4'd2, 0);
        chk("mk9.nz", 64'(bus.busy_o != '0), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("async");
        bus.write_enable0_i    = 1'b1;
        bus.reg_write_index0_i = 4'd2;
        bus.value0_i           = 32'hDEADBEEF;
        bus.mark_i             = 1'b1;
        bus.mark_index_i       = 4'd4;
        bus.rd_index_i         = {4'd2, 4'd2};
        @(posedge clk);
        #1;
        chk_zero("hold");
        idle();
        rst = 1'b0;
        for (int i = 0; i < D; i++) mdl[i] = '0;
        mbusy = '0;
        step("post", 0, 0, 0, 0, 0, 0, 0, 0, 4'd2, 4'd4);
        chk("post.lit", 64'(bus.rd_value_o[DW-1:0]), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/cpu_regfile_bypass.md
CPU_REGFILE_BYPASS -- requirements
Module: cpu_regfile_bypass

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter ADDR_W, default 4: index width; depth DEPTH = 2**ADDR_W.
REQ-003 Parameter NUM_RD, default 2: number of read ports, legal range 1..4.
REQ-004 Parameter FP_IDX, default 0: index tapped to fp_o.
REQ-005 Parameter SP_IDX, default 1: index tapped to sp_o.
REQ-006 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-007 rst_i  in  1  asynchronous, active-high reset.
REQ-008 write_enable0_i  in  1  write port 0 enable.
REQ-009 reg_write_index0_i  in  ADDR_W  write port 0 index.
REQ-010 value0_i  in  DATA_W  write port 0 data.
REQ-011 write_enable1_i  in  1  write port 1 enable.
REQ-012 reg_write_index1_i  in  ADDR_W  write port 1 index.
REQ-013 value1_i  in  DATA_W  write port 1 data.
REQ-014 rd_index_i  in  NUM_RD*ADDR_W  packed read indices; port k occupies bits [k*ADDR_W +: ADDR_W].
REQ-015 rd_value_o  out  NUM_RD*DATA_W  packed registered read data; port k at [k*DATA_W +: DATA_W].
REQ-016 mark_i  in  1  request to set the busy bit of mark_index_i.
REQ-017 mark_index_i  in  ADDR_W  register to mark pending.
REQ-018 busy_o  out  DEPTH  scoreboard; bit i = 1 means register i has an outstanding write.
REQ-019 rd_busy_o  out  NUM_RD  registered busy flag per read port, aligned with rd_value_o.
REQ-020 fp_o  out  DATA_W  current contents of FP_IDX, flop output, no bypass.
REQ-021 sp_o  out  DATA_W  current contents of SP_IDX, flop output, no bypass.

Function
REQ-022 Write: on each edge, each enabled write port stores its value at its index.
REQ-023 Write collision: both ports enabled with equal index -> port 1 value stored, port 0 discarded.
REQ-024 Read latency: exactly 1 cycle; rd_value_o port k at edge N+1 reflects rd_index_i port k sampled at edge N.
REQ-025 Write-first bypass: read index equal to an enabled write index in the same cycle -> rd_value_o returns the incoming write data, not the old array value.
REQ-026 Bypass priority: port 1 write data over port 0 write data over array contents (consistent with REQ-023).
REQ-027 Read ports are independent; any number of ports may read the same index in a cycle.
REQ-028 Scoreboard clear: an enabled write to index i clears busy bit i at that edge.
REQ-029 Scoreboard set: mark_i sets busy bit mark_index_i at that edge.
REQ-030 Set/clear same index, same edge -> bit ends at 1 (new pending op wins).
REQ-031 Mark of an already-busy index -> no change (bit stays 1); no counting.
REQ-032 rd_busy_o port k = busy bit of the sampled index after applying that edge's set/clear (same bypass view as REQ-025).
REQ-033 fp_o/sp_o update one cycle after a write to FP_IDX/SP_IDX.
REQ-034 No stalls, no back-pressure; every input is consumed every cycle.

Reset
REQ-035 rst_i asserted -> immediately, without waiting for a clock edge: all DEPTH registers = 0, rd_value_o = 0, rd_busy_o = 0, busy_o = 0, fp_o = 0, sp_o = 0.
REQ-036 While rst_i is high, writes, marks and reads are ignored; outputs hold 0.
REQ-037 Reset mid-operation discards pending writes and busy bits; the first edge after release behaves as a fresh cycle.

Verification
REQ-038 Reset release; write idx 2 = 0x11223344; next cycle read port0 idx 2 -> rd_value_o[0] = 0x11223344 one cycle later.
REQ-039 Same cycle: write idx 5 = 0xA5A5A5A5 and read port1 idx 5 -> rd_value_o[1] = 0xA5A5A5A5 next cycle (bypass), array holds 0xA5A5A5A5.
REQ-040 Both ports write idx 3 (port0 0x1, port1 0x2) while port0 reads 3 -> rd_value_o[0] = 0x2; later read of 3 -> 0x2.
REQ-041 mark idx 7 -> busy_o[7] = 1; write idx 7 with mark idx 7 same cycle -> busy_o[7] stays 1; next write idx 7 alone -> busy_o[7] = 0.
REQ-042 Write FP_IDX = 0x1000, SP_IDX = 0x2000 same cycle -> fp_o = 0x1000, sp_o = 0x2000 next cycle.
REQ-043 Assert rst_i asynchronously between edges with busy_o nonzero and registers loaded -> all outputs 0 before the next edge; subsequent read of idx 2 -> 0.
